uart_tx_arbiter: RTL and testbench

Shares one UART transmitter (8-bit buffered, 16x-oversampled) between NUM_REQ byte-stream requesters. Each requester sends packets: runs of bytes, with the final byte flagged last. A granted requester keeps the transmitter until its last byte has been accepted or its packet times out, so bytes from different packets never interleave on the serial line. Packets are granted round-robin. The block sits between the requesters and the transmitter's wr_tx/wr_data/tbr interface.

---
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one buffered UART transmitter among NUM_REQ byte streams.
// Optional: define UART_ARB_PRIO0_EN to make requester 0 win every packet-boundary arbitration it enters.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [NUM_REQ-1:0]     grant,
   input  logic                   tbr,
   output logic                   wr_tx,
   output logic [7:0]             wr_data,
   output logic                   pkt_abort,
   output logic                   busy
);

   localparam int unsigned        IDX_W   = $clog2(NUM_REQ);
   localparam int unsigned        CNT_W   = 16;
   localparam logic [CNT_W-1:0]   TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [IDX_W-1:0]   PTR_RST = IDX_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   r_owner;
   logic               r_last;
   logic [CNT_W-1:0]   r_cnt;
   logic [NUM_REQ-1:0] r_grant;
   logic               r_wr_tx;
   logic [7:0]         r_wr_data;
   logic               r_abort;
   logic               r_busy;

   logic [7:0]         w_bytes [NUM_REQ];
   logic [IDX_W-1:0]   w_j;
   logic [IDX_W-1:0]   w_rr_idx;
   logic               w_rr_hit;
   logic [IDX_W-1:0]   w_win_idx;
   logic               w_accept;
   logic [IDX_W-1:0]   w_acc_idx;
   logic [IDX_W-1:0]   w_ptr_rel;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         w_bytes[i] = req_data[8*i +: 8];
      end
   end

   // First valid requester scanning upward from pointer+1, wrapping
   always_comb begin
      w_j      = '0;
      w_rr_idx = '0;
      w_rr_hit = 1'b0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         w_j = IDX_W'((32'(r_ptr) + k) % NUM_REQ);
         if (!w_rr_hit && req_valid[w_j]) begin
            w_rr_hit = 1'b1;
            w_rr_idx = w_j;
         end
      end
   end

   // Winner selection and pointer value used when a packet releases the grant
   always_comb begin
      w_win_idx = w_rr_idx;
      w_ptr_rel = r_owner;
`ifdef UART_ARB_PRIO0_EN
      if (req_valid[0]) begin
         w_win_idx = '0;
      end
      if (r_owner == '0) begin
         w_ptr_rel = r_ptr;
      end
`endif
   end

   // Byte acceptance: any requester at a packet boundary, only the owner mid-packet
   always_comb begin
      w_accept  = 1'b0;
      w_acc_idx = r_owner;
      req_ready = '0;
      case (r_state)
         S_IDLE: begin
            if (tbr && w_rr_hit) begin
               w_accept  = 1'b1;
               w_acc_idx = w_win_idx;
            end
         end
         S_HOLD: begin
            if (tbr && req_valid[r_owner]) begin
               w_accept = 1'b1;
            end
         end
         default: ;
      endcase
      if (w_accept) begin
         req_ready[w_acc_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_ptr     <= PTR_RST;
         r_owner   <= '0;
         r_last    <= 1'b0;
         r_cnt     <= '0;
         r_grant   <= '0;
         r_wr_tx   <= 1'b0;
         r_wr_data <= 8'h00;
         r_abort   <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_wr_tx <= 1'b0;
         r_abort <= 1'b0;
         if (w_accept) begin
            r_state   <= S_ISSUE;
            r_owner   <= w_acc_idx;
            r_grant   <= NUM_REQ'(1) << w_acc_idx;
            r_wr_data <= w_bytes[w_acc_idx];
            r_last    <= req_last[w_acc_idx];
            r_wr_tx   <= 1'b1;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
         end else begin
            case (r_state)
               S_ISSUE: begin
                  if (r_last) begin
                     r_state <= S_IDLE;
                     r_grant <= '0;
                     r_ptr   <= w_ptr_rel;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= S_HOLD;
                     r_cnt   <= '0;
                  end
               end
               S_HOLD: begin
                  // Owner went quiet too long: drop the packet so others can use the line
                  if (r_cnt + CNT_W'(1) == TIMEOUT) begin
                     r_abort <= 1'b1;
                     r_state <= S_IDLE;
                     r_grant <= '0;
                     r_ptr   <= w_ptr_rel;
                     r_cnt   <= '0;
                     r_busy  <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign grant     = r_grant;
   assign wr_tx     = r_wr_tx;
   assign wr_data   = r_wr_data;
   assign pkt_abort = r_abort;
   assign busy      = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet-level reference model checked every cycle plus directed literal checks.
// Build with +define+UART_ARB_PRIO0_EN to exercise the requester-0 priority variant.
module tb_uart_tx_arbiter;

   localparam int NR      = 4;
   localparam int TO      = 8;
   localparam int TX_CHAR = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NR-1:0]   req_valid, req_last, req_ready, grant;
   logic [8*NR-1:0] req_data;
   logic            tbr, wr_tx, pkt_abort, busy;
   logic [7:0]      wr_data;

   uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .grant     (grant),
      .tbr       (tbr),
      .wr_tx     (wr_tx),
      .wr_data   (wr_data),
      .pkt_abort (pkt_abort),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Requester sources: per-requester list of {last, byte}
   logic [8:0] smem [NR][16];
   int         hd [NR];
   int         tl [NR];
   bit         tx_model;
   int         tx_cnt;
   bit         seen_wr;

   task automatic push(input int r, input logic last, input logic [7:0] b);
      smem[r][tl[r]] = {last, b};
      tl[r]++;
   endtask

   task automatic present();
      for (int i = 0; i < NR; i++) begin
         req_valid[i]       = (hd[i] < tl[i]);
         req_data[8*i +: 8] = (hd[i] < tl[i]) ? smem[i][hd[i]][7:0] : 8'h00;
         req_last[i]        = (hd[i] < tl[i]) ? smem[i][hd[i]][8] : 1'b0;
      end
   endtask

   // One clock: sample acceptance, then advance sources and the transmitter's tbr
   task automatic cycle();
      logic [NR-1:0] acc;
      @(negedge clk);
      acc = rst_n ? req_ready : '0;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (acc[i]) hd[i]++;
      if (tx_model) begin
         if (seen_wr) begin
            tbr    = 1'b0;
            tx_cnt = TX_CHAR;
         end else if (tx_cnt > 0) begin
            tx_cnt = tx_cnt - 1;
            if (tx_cnt == 0) tbr = 1'b1;
         end
      end
      seen_wr = wr_tx;
      present();
   endtask

   // Reference model state: owner, write-in-flight flag, idle count, pointer
   int         m_owner, m_ptr, m_idle;
   bit         m_wrote, m_last;
   logic [NR-1:0] e_grant;
   logic       e_wr_tx, e_abort, e_busy;
   logic [7:0] e_wr_data;

   function automatic void model_reset();
      m_owner = -1; m_ptr = NR - 1; m_idle = 0; m_wrote = 0; m_last = 0;
      e_grant = '0; e_wr_tx = 0; e_abort = 0; e_busy = 0; e_wr_data = 8'h00;
   endfunction

   function automatic logic [NR-1:0] model_ready();
      logic [NR-1:0] r;
      int w;
      r = '0;
      w = -1;
      if (m_wrote || !tbr) return r;
      if (m_owner >= 0) begin
         if (req_valid[m_owner]) r[m_owner] = 1'b1;
         return r;
      end
`ifdef UART_ARB_PRIO0_EN
      if (req_valid[0]) w = 0;
`endif
      for (int k = 1; k <= NR && w < 0; k++)
         if (req_valid[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
      if (w >= 0) r[w] = 1'b1;
      return r;
   endfunction

   function automatic void model_release();
`ifdef UART_ARB_PRIO0_EN
      if (m_owner != 0) m_ptr = m_owner;
`else
      m_ptr = m_owner;
`endif
      m_owner = -1;
   endfunction

   function automatic void model_step(input logic [NR-1:0] rdy);
      int a;
      a = -1;
      for (int i = 0; i < NR; i++) if (rdy[i]) a = i;
      e_wr_tx = (a >= 0);
      e_abort = 1'b0;
      if (m_wrote) begin
         m_wrote = 0;
         if (m_last) model_release();
         else m_idle = 0;
      end else if (a >= 0) begin
         m_owner   = a;
         m_wrote   = 1;
         m_last    = req_last[a];
         e_wr_data = req_data[8*a +: 8];
         m_idle    = 0;
      end else if (m_owner >= 0) begin
         m_idle++;
         if (m_idle == TO) begin
            e_abort = 1'b1;
            model_release();
         end
      end
      e_grant = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
      e_busy  = (m_owner >= 0);
   endfunction

   // Monitor records for directed checks
   int   wl_req [64];
   logic [7:0] wl_dat [64];
   int   wn, dbl_wr, n_abort, abort_cyc;
   int   first_acc [NR];
   int   last_acc [NR];
   bit   prev_wr;

   function automatic int oh2idx(input logic [NR-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < NR; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic clear_mon();
      wn = 0; dbl_wr = 0; n_abort = 0; abort_cyc = -1; prev_wr = 0;
      for (int i = 0; i < NR; i++) begin
         first_acc[i] = -1;
         last_acc[i]  = -1;
      end
   endtask

   // Per-cycle comparison against the model, then model advance
   always @(negedge clk) begin
      logic [NR-1:0] er;
      if (!rst_n) model_reset();
      er = model_ready();
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("grant", 32'(grant), 32'(e_grant));
      chk("wr_tx", 32'(wr_tx), 32'(e_wr_tx));
      chk("wr_data", 32'(wr_data), 32'(e_wr_data));
      chk("pkt_abort", 32'(pkt_abort), 32'(e_abort));
      chk("busy", 32'(busy), 32'(e_busy));
      if (wr_tx && wn < 64) begin
         wl_req[wn] = oh2idx(grant);
         wl_dat[wn] = wr_data;
         wn++;
      end
      if (wr_tx && prev_wr) dbl_wr++;
      prev_wr = wr_tx;
      if (pkt_abort) begin
         n_abort++;
         abort_cyc = cyc;
      end
      for (int i = 0; i < NR; i++) begin
         if (rst_n && req_ready[i]) begin
            if (first_acc[i] < 0) first_acc[i] = cyc;
            if (req_last[i]) last_acc[i] = cyc;
         end
      end
      if (rst_n) model_step(er);
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      for (int i = 0; i < NR; i++) begin
         hd[i] = 0;
         tl[i] = 0;
      end
      present();
      tbr = 1'b1; tx_cnt = 0; seen_wr = 0; tx_model = 1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_mon();
   endtask

   task automatic run_done(input string name, input int budget);
      int n;
      bit done;
      n = 0;
      done = 0;
      while (!done && n < budget) begin
         cycle();
         n++;
         done = 1;
         for (int i = 0; i < NR; i++) if (hd[i] < tl[i]) done = 0;
         if (busy || wr_tx) done = 0;
      end
      chk({name, "_done"}, 32'(done), 32'd1);
   endtask

   int         e2r [10] = '{0, 0, 0, 2, 2, 2, 3, 0, 1, 2};
   logic [7:0] e2d [6]  = '{8'h10, 8'h11, 8'h12, 8'h30, 8'h31, 8'h32};
   int         e3r [5]  = '{1, 1, 1, 3, 3};
   int         h0;

   initial begin
      rst_n = 1'b0; tbr = 1'b1; tx_model = 1; tx_cnt = 0; seen_wr = 0;
      req_valid = '0; req_data = '0; req_last = '0;
      for (int i = 0; i < NR; i++) begin
         hd[i] = 0;
         tl[i] = 0;
      end
      clear_mon();

      // Reset values and single-byte packet latency
      do_reset();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_wr_tx", 32'(wr_tx), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'h00);
      chk("rst_abort", 32'(pkt_abort), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      push(0, 1'b1, 8'h41);
      present();
      #1;
      chk("t1_ready", 32'(req_ready), 32'b0001);
      cycle();
      chk("t1_wr_tx", 32'(wr_tx), 32'd1);
      chk("t1_wr_data", 32'(wr_data), 32'h41);
      chk("t1_grant", 32'(grant), 32'b0001);
      cycle();
      chk("t1_grant_rel", 32'(grant), 32'd0);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_wr_tx_off", 32'(wr_tx), 32'd0);

      // Packets never interleave; rotation continues from the last owner
      do_reset();
      push(0, 0, 8'h10); push(0, 0, 8'h11); push(0, 1, 8'h12);
      push(2, 0, 8'h30); push(2, 0, 8'h31); push(2, 1, 8'h32);
      present();
      run_done("t2a", 200);
      for (int i = 0; i < NR; i++) push(i, 1'b1, 8'(8'h80 + i));
      present();
      run_done("t2b", 200);
      chk("t2_count", 32'(wn), 32'd10);
      for (int i = 0; i < 10; i++) chk($sformatf("t2_req%0d", i), 32'(wl_req[i]), 32'(e2r[i]));
      for (int i = 0; i < 6; i++) chk($sformatf("t2_dat%0d", i), 32'(wl_dat[i]), 32'(e2d[i]));

      // Competing requester is locked out until the owner's last byte
      do_reset();
      push(1, 0, 8'h21); push(1, 0, 8'h22); push(1, 1, 8'h23);
      push(3, 0, 8'h91); push(3, 1, 8'h92);
      present();
      run_done("t3", 200);
      chk("t3_lockout", 32'(first_acc[3] > last_acc[1]), 32'd1);
      for (int i = 0; i < 5; i++) chk($sformatf("t3_req%0d", i), 32'(wl_req[i]), 32'(e3r[i]));

      // Timeout: accept at a, ISSUE a+1, HOLD from a+2, abort visible at a+10
      do_reset();
      push(2, 0, 8'h52);
      push(3, 1, 8'h53);
      present();
      run_done("t4", 100);
      chk("t4_abort_cnt", 32'(n_abort), 32'd1);
      chk("t4_abort_lat", 32'(abort_cyc - first_acc[2]), 32'd10);
      chk("t4_next_owner", 32'(first_acc[3]), 32'(abort_cyc));
      chk("t4_req1", 32'(wl_req[1]), 32'd3);

      // Back-to-back writes with tbr stuck high, and none with tbr stuck low
      do_reset();
      tx_model = 0;
      for (int i = 0; i < 10; i++) push(0, 1'(i == 9), 8'(8'hA0 + i));
      present();
      run_done("t5a", 100);
      chk("t5_dbl", 32'(dbl_wr), 32'd0);
      chk("t5_count", 32'(wn), 32'd10);
      tbr = 1'b0;
      push(0, 0, 8'hB0); push(0, 0, 8'hB1); push(0, 1, 8'hB2);
      present();
      h0 = hd[0];
      repeat (20) cycle();
      chk("t5_stall_wr", 32'(wn), 32'd10);
      chk("t5_stall_acc", 32'(hd[0]), 32'(h0));
      tbr = 1'b1;
      tx_model = 1;
      run_done("t5b", 100);
      chk("t5_drain", 32'(wn), 32'd13);

      // Requester 0 re-arbitrates against requester 1 right after finishing
      do_reset();
      push(0, 1, 8'h60);
      present();
      run_done("t6a", 50);
      push(0, 1, 8'h61);
      push(1, 1, 8'h70);
      present();
      run_done("t6b", 50);
`ifdef UART_ARB_PRIO0_EN
      chk("t6_second", 32'(wl_req[1]), 32'd0);
      chk("t6_third", 32'(wl_req[2]), 32'd1);
`else
      chk("t6_second", 32'(wl_req[1]), 32'd1);
      chk("t6_third", 32'(wl_req[2]), 32'd0);
`endif

      // Reset mid-packet returns outputs to reset values immediately
      do_reset();
      push(0, 0, 8'hC0); push(0, 0, 8'hC1); push(0, 1, 8'hC2);
      present();
      cycle();
      cycle();
      chk("t7_busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      for (int i = 0; i < NR; i++) begin
         hd[i] = 0;
         tl[i] = 0;
      end
      present();
      #1;
      chk("t7_grant", 32'(grant), 32'd0);
      chk("t7_wr_tx", 32'(wr_tx), 32'd0);
      chk("t7_wr_data", 32'(wr_data), 32'h00);
      chk("t7_busy", 32'(busy), 32'd0);
      cycle();
      rst_n = 1'b1;
      repeat (3) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
      $fatal(1);
   end

endmodule
